bus_arbiter_2: RTL

Two-requester round-robin arbiter that shares one host-side bus port (address, write data, write mask, ren, wen, read data, ready) between two bus masters, e.g. instruction fetch and load/store. Sits between the masters and the host port of the bus hub. Grants whole transactions, holding the grant from request to `ready`, and forwards only the granted master's signals downstream.

---
 rtl/bus_arbiter_2.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_2.sv
// Two-master round-robin bus arbiter: grants whole transactions and forwards the winner to one host port.
// Optional watchdog enabled with `define BUS_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module bus_arbiter_2 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_address,
  input  logic [31:0] m1_address,
  input  logic [31:0] m0_data_write,
  input  logic [31:0] m1_data_write,
  input  logic [3:0]  m0_write_mask,
  input  logic [3:0]  m1_write_mask,
  input  logic        m0_ren,
  input  logic        m1_ren,
  input  logic        m0_wen,
  input  logic        m1_wen,
  output logic [31:0] m0_data_read,
  output logic [31:0] m1_data_read,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_write,
  output logic [3:0]  bus_write_mask,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [31:0] bus_data_read,
  input  logic        bus_ready,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last;
  logic   req0, req1;
  logic   expire;
  logic   done;

  assign req0 = m0_ren | m0_wen;
  assign req1 = m1_ren | m1_wen;
  assign done = (state != IDLE) & (bus_ready | expire);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES <= 256) ? 8 : ((TIMEOUT_CYCLES <= 65536) ? 16 : 32);

  logic [CW-1:0] wd_count;

  assign expire = (state != IDLE) & ~bus_ready & (wd_count == CW'(TIMEOUT_CYCLES - 1));

  // Count starts at 0 on every grant entry because IDLE and completion both clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE || done)
        wd_count <= '0;
      else
        wd_count <= wd_count + 1'b1;
      if (expire)
        timeout_err <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // The completing master is skipped at its done edge since its request is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            state <= last ? GNT0 : GNT1;
            last  <= ~last;
          end else if (req0) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (req1) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: begin
          if (done) begin
            if (req1) begin
              state <= GNT1;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (done) begin
            if (req0) begin
              state <= GNT0;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus_address    = '0;
    bus_data_write = '0;
    bus_write_mask = '0;
    bus_ren        = 1'b0;
    bus_wen        = 1'b0;
    m0_data_read   = '0;
    m1_data_read   = '0;
    m0_ready       = 1'b0;
    m1_ready       = 1'b0;
    case (state)
      GNT0: begin
        bus_address    = m0_address;
        bus_data_write = m0_data_write;
        bus_write_mask = m0_write_mask;
        bus_ren        = m0_ren;
        bus_wen        = m0_wen;
        m0_ready       = done;
        m0_data_read   = expire ? 32'hDEAD_BEEF : bus_data_read;
      end
      GNT1: begin
        bus_address    = m1_address;
        bus_data_write = m1_data_write;
        bus_write_mask = m1_write_mask;
        bus_ren        = m1_ren;
        bus_wen        = m1_wen;
        m1_ready       = done;
        m1_data_read   = expire ? 32'hDEAD_BEEF : bus_data_read;
      end
      default: ;
    endcase
  end

endmodule
